bus_access_arbiter: RTL

- Tracks I3C/I2C bus occupancy from bus_monitor event/state outputs: BUSY after START, bus free after STOP + t_BUF, bus available after t_AVAL of SCL/SDA idle-high.
- Round-robin arbitrates local bus initiators (controller FSM, IBI, hot-join) that want to issue a START.
- Grants only while the bus is free.
- Sits between bus_monitor and the PHY-driving state machines in src/ctrl.

---
 rtl/bus_access_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bus_access_arbiter.sv
// Bus occupancy tracker (BUSY / free / available) from bus_monitor events,
// plus a round-robin START arbiter for the local initiators.
module bus_access_arbiter #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned CntW   = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              start_det_i,
  input  logic              rstart_det_i,
  input  logic              stop_det_i,
  input  logic              scl_stable_high_i,
  input  logic              sda_stable_high_i,
  input  logic [CntW-1:0]   t_buf_i,
  input  logic [CntW-1:0]   t_aval_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              gnt_valid_o,
  output logic              bus_busy_o,
  output logic              bus_free_o,
  output logic              bus_available_o
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {
    ST_BUSY = 1'b0,
    ST_IDLE = 1'b1
  } bus_state_e;

  bus_state_e        state_q;
  logic [CntW-1:0]   idle_cnt_q;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;

  logic            start_any;
  logic            lines_idle;
  logic            buf_met;
  logic            aval_met;
  logic            grant_ok;
  logic            sel_found;
  logic [PtrW-1:0] sel_idx;
  logic [PtrW:0]   cand;
  logic [PtrW:0]   ptr_inc;

  assign start_any  = start_det_i | rstart_det_i;
  assign lines_idle = scl_stable_high_i & sda_stable_high_i;
  assign buf_met    = (idle_cnt_q >= t_buf_i);
  assign aval_met   = (idle_cnt_q >= t_aval_i);

  // Bus occupancy FSM and idle-line counter. START beats a same-cycle STOP.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_BUSY;
      idle_cnt_q <= '0;
    end else if (!enable_i || start_any) begin
      state_q    <= ST_BUSY;
      idle_cnt_q <= '0;
    end else if (stop_det_i) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
    end else begin
      if (state_q == ST_BUSY && aval_met) begin
        state_q <= ST_IDLE;
      end
      if (!lines_idle) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != '1) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
    end
  end

  assign bus_busy_o      = (state_q == ST_BUSY);
  assign bus_free_o      = (state_q == ST_IDLE) && buf_met;
  assign bus_available_o = (state_q == ST_IDLE) && aval_met;

  // First requester at or after rr_ptr_q, wrapping modulo NumReq.
  // NOTE: every variable written in always_comb gets a default up front, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
      if (cand >= (PtrW+1)'(NumReq)) begin
        cand = cand - (PtrW+1)'(NumReq);
      end
      if (!sel_found && req_i[cand[PtrW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PtrW-1:0];
      end
    end
  end

  assign ptr_inc  = {1'b0, sel_idx} + (PtrW+1)'(1);
  assign grant_ok = enable_i && !gnt_valid_o && bus_free_o && !start_any && sel_found;

  always_comb begin
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    if (!enable_i) begin
      gnt_d = '0;
    end else if (gnt_valid_o) begin
      // The holder keeps the grant through its own START; only its request drop releases it.
      if (!(|(gnt_q & req_i))) begin
        gnt_d = '0;
      end
    end else if (grant_ok) begin
      for (int i = 0; i < NumReq; i++) begin
        gnt_d[i] = (sel_idx == PtrW'(i));
      end
      rr_ptr_d = (ptr_inc == (PtrW+1)'(NumReq)) ? '0 : ptr_inc[PtrW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;

endmodule
